// File: rtl/param_lifo.sv
// ---------------------------------------------------------------------------
// param_lifo : parametrised LIFO stack, registered pop data, replace on push+pop
// Optional sticky error flags: define PARAM_LIFO_ERR_FLAGS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_lifo #(
   parameter  int WIDTH       = 8,
   parameter  int DEPTH       = 8,
   parameter  int AFULL_LEVEL = DEPTH - 1,
   localparam int CW          = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wn,
   input  logic             rn,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    sp;
   logic [CW-1:0]    sp_m1;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    push_idx;

   logic do_replace;
   logic do_bypass;
   logic do_push;
   logic do_pop;
   logic rej_push;
   logic rej_pop;

   assign count       = sp;
   assign empty       = (sp == '0);
   assign full        = (sp == CW'(DEPTH));
   assign almost_full = (sp >= CW'(AFULL_LEVEL));

   assign sp_m1    = sp - CW'(1);
   assign top_idx  = sp_m1[AW-1:0];
   assign push_idx = sp[AW-1:0];

   assign do_replace = wn &  rn & !empty;
   assign do_bypass  = wn &  rn &  empty;
   assign do_push    = wn & !rn & !full;
   assign do_pop     = rn & !wn & !empty;
   assign rej_push   = wn & !rn &  full;
   assign rej_pop    = rn & !wn &  empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         sp         <= '0;
         dataout    <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= do_replace | do_bypass | do_pop;
         if (do_replace || do_pop) begin
            dataout <= mem[top_idx];
         end else if (do_bypass) begin
            dataout <= datain;
         end
         if (do_push) begin
            sp <= sp + CW'(1);
         end else if (do_pop) begin
            sp <= sp_m1;
         end
      end
   end

   // Storage is not reset; writes are only suppressed during the reset cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (do_replace) begin
            mem[top_idx] <= datain;
         end else if (do_push) begin
            mem[push_idx] <= datain;
         end
      end
   end

`ifdef PARAM_LIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic unf_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (rej_push) ovf_q <= 1'b1;
         if (rej_pop)  unf_q <= 1'b1;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_rej;
   assign unused_rej = rej_push | rej_pop;
   assign overflow   = 1'b0;
   assign underflow  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_lifo.sv
// ---------------------------------------------------------------------------
// tb_param_lifo : directed + random test of param_lifo against a queue model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_lifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFL   = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wn = 1'b0;
   logic             rn = 1'b0;
   logic [WIDTH-1:0] datain = '0;
   logic [WIDTH-1:0] dataout;
   logic             dout_valid, full, empty, almost_full, overflow, underflow;
   logic [CW-1:0]    count;

   param_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
      .clock(clk), .reset(rst), .wn(wn), .rn(rn), .datain(datain),
      .dataout(dataout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // behavioural model
   logic [WIDTH-1:0] stk[$];
   logic [WIDTH-1:0] m_dout  = '0;
   logic             m_valid = 1'b0;
   logic             m_ovf   = 1'b0;
   logic             m_unf   = 1'b0;
   bit               checking = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit w, input bit p, input logic [WIDTH-1:0] d);
      if (r) begin
         stk.delete();
         m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (w && p) begin
         m_valid = 1'b1;
         if (stk.size() > 0) begin
            m_dout = stk[stk.size()-1];
            stk[stk.size()-1] = d;
         end else begin
            m_dout = d;
         end
      end else if (w) begin
         m_valid = 1'b0;
         if (stk.size() < DEPTH) stk.push_back(d);
         else m_ovf = 1'b1;
      end else if (p) begin
         if (stk.size() > 0) begin
            m_dout  = stk.pop_back();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
            m_unf   = 1'b1;
         end
      end else begin
         m_valid = 1'b0;
      end
   endtask

   // one clock cycle: apply inputs, clock, advance model
   task automatic cyc(input bit r, input bit w, input bit p, input logic [WIDTH-1:0] d);
      rst = r; wn = w; rn = p; datain = d;
      @(posedge clk);
      model_step(r, w, p, d);
      #2;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("count",       32'(count),       32'(stk.size()));
         chk("empty",       32'(empty),       32'(stk.size() == 0));
         chk("full",        32'(full),        32'(stk.size() == DEPTH));
         chk("almost_full", 32'(almost_full), 32'(stk.size() >= AFL));
         chk("dout_valid",  32'(dout_valid),  32'(m_valid));
         chk("dataout",     32'(dataout),     32'(m_dout));
`ifdef PARAM_LIFO_ERR_FLAGS_EN
         chk("overflow",    32'(overflow),    32'(m_ovf));
         chk("underflow",   32'(underflow),   32'(m_unf));
`else
         chk("overflow",    32'(overflow),    32'd0);
         chk("underflow",   32'(underflow),   32'd0);
`endif
      end
   end

   initial begin
      #2;
      cyc(1, 0, 0, 8'h00);
      checking = 1'b1;
      cyc(1, 1, 1, 8'h55);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_dataout", 32'(dataout), 0);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);

      // push 100,150,200 then pop three times
      cyc(0, 1, 0, 8'd100);
      cyc(0, 1, 0, 8'd150);
      chk("af_at2", 32'(almost_full), 0);
      cyc(0, 1, 0, 8'd200);
      chk("af_at3", 32'(almost_full), 1);
      cyc(0, 0, 1, 8'd0);
      chk("pop1", 32'(dataout), 200);
      chk("pop1_v", 32'(dout_valid), 1);
      chk("pop1_af", 32'(almost_full), 0);
      cyc(0, 0, 1, 8'd0);
      chk("pop2", 32'(dataout), 150);
      cyc(0, 0, 1, 8'd0);
      chk("pop3", 32'(dataout), 100);
      chk("pop3_empty", 32'(empty), 1);

      // fill and overflow
      for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 8'(i));
      chk("ovf_full", 32'(full), 1);
      chk("ovf_count", 32'(count), 4);
`ifdef PARAM_LIFO_ERR_FLAGS_EN
      chk("ovf_flag", 32'(overflow), 1);
`endif
      cyc(0, 0, 1, 8'd0);
      chk("ovf_pop", 32'(dataout), 4);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'd0);
      chk("drain_last", 32'(dataout), 1);

      // underflow from empty
      cyc(0, 0, 1, 8'd0);
`ifdef PARAM_LIFO_ERR_FLAGS_EN
      chk("unf_flag", 32'(underflow), 1);
`endif
      chk("unf_valid", 32'(dout_valid), 0);
      chk("unf_hold", 32'(dataout), 1);
      chk("unf_count", 32'(count), 0);

      // replace and bypass
      cyc(0, 1, 0, 8'd10);
      cyc(0, 1, 0, 8'd20);
      cyc(0, 1, 1, 8'd30);
      chk("repl_dout", 32'(dataout), 20);
      chk("repl_valid", 32'(dout_valid), 1);
      chk("repl_count", 32'(count), 2);
      cyc(0, 0, 1, 8'd0);
      chk("repl_pop1", 32'(dataout), 30);
      cyc(0, 0, 1, 8'd0);
      chk("repl_pop2", 32'(dataout), 10);
      cyc(0, 1, 1, 8'd77);
      chk("byp_dout", 32'(dataout), 77);
      chk("byp_count", 32'(count), 0);

      // reset mid-operation with wn high
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(40 + i));
      cyc(1, 1, 0, 8'd99);
      chk("mrst_count", 32'(count), 0);
      chk("mrst_empty", 32'(empty), 1);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_unf", 32'(underflow), 0);
      cyc(0, 0, 1, 8'd0);
`ifdef PARAM_LIFO_ERR_FLAGS_EN
      chk("mrst_unf_after", 32'(underflow), 1);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(63) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
      end

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/param_lifo.md
# param_lifo

Parametrised LIFO stack, the next generation of the fixed 8-bit LIFO. Adds configurable width, depth and almost-full threshold, an occupancy count, and a registered output with a valid strobe. Simultaneous push and pop performs a top-of-stack replace. Sticky overflow/underflow error flags are optional. It sits between a producer and a consumer in the same clock domain, as local scratch storage for sequential datapaths.

## Interface

- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries (≥2; need not be a power of two)
- `AFULL_LEVEL`, DEPTH-1, `almost_full` asserts when count ≥ this value (1..DEPTH)
- `CW`, $clog2(DEPTH+1), count width (derived localparam, not overridable)

- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `wn`  in  1  push request
- `rn`  in  1  pop request
- `datain`  in  WIDTH  push data
- `dataout`  out  WIDTH  registered popped word
- `dout_valid`  out  1  high for one cycle when `dataout` was updated by the previous edge
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AFULL_LEVEL
- `count`  out  CW  current occupancy
- `overflow`  out  1  sticky: a push was rejected
- `underflow`  out  1  sticky: a pop was rejected

## Operation

- State: storage array `mem[0..DEPTH-1]`, stack pointer `sp` (= `count`), `dataout` register, `dout_valid`, error flags. The top of stack is `mem[sp-1]`.
- Reset values: `sp`=0, `dataout`=0, `dout_valid`=0, `overflow`=0, `underflow`=0, giving `empty`=1, `full`=0, `almost_full`=(AFULL_LEVEL==0 ? 1 : 0), `count`=0. Memory contents are not reset.
- Per edge, priority ordered:
  - `reset`: load the reset values. Overrides `wn`/`rn`.
  - `wn` & `rn` & !empty: replace. `dataout`←`mem[sp-1]`, then `mem[sp-1]`←`datain`, `dout_valid`←1, `sp` unchanged. Legal when full.
  - `wn` & `rn` & empty: bypass. `dataout`←`datain`, `dout_valid`←1, `sp` stays 0, memory untouched.
  - `wn` only, !full: `mem[sp]`←`datain`, `sp`←`sp`+1, `dout_valid`←0.
  - `wn` only, full: ignored, `overflow`←1, `dout_valid`←0.
  - `rn` only, !empty: `dataout`←`mem[sp-1]`, `sp`←`sp`-1, `dout_valid`←1.
  - `rn` only, empty: `dataout` holds, `dout_valid`←0, `underflow`←1.
  - Idle: `dataout` holds, `dout_valid`←0.
- `full`, `empty`, `almost_full` and `count` are combinational decodes of `sp`; no extra flag registers.
- Pointer arithmetic is unsigned in CW bits. `sp` never exceeds DEPTH and never wraps below 0.
- Error flags are sticky until `reset`. They never block operation.

## Timing

- Pop latency: 1 cycle. `rn` sampled at edge N, so `dataout`/`dout_valid` are valid after edge N and until edge N+1.
- Push is visible to a pop at the next edge: push at N, pop at N+1, returns that word after N+1.
- Flags update after the same edge as `sp`. Back-to-back push/pop every cycle is supported with no bubbles.
- Reset mid-operation discards all contents in one cycle. `wn`/`rn` in the reset cycle have no effect.

## Configuration

- `PARAM_LIFO_ERR_FLAGS_EN` defined: `overflow`/`underflow` are implemented as described.
- Not defined: both ports are tied to constant 0 and the flag registers are not built. All other behaviour is identical, and rejected push/pop are still silently ignored.

## Test plan

All scenarios use WIDTH=8, DEPTH=4, AFULL_LEVEL=3 and define the macro.

- Reset → `empty`=1, `full`=0, `count`=0, `dataout`=0, `dout_valid`=0, both error flags 0.
- Push 100, 150, 200, then `rn` for 3 cycles → `dataout` = 200, 150, 100 on consecutive cycles, `dout_valid`=1 each cycle; `empty`=1 after the third pop. `almost_full`=1 only while count was 3.
- Push 1, 2, 3, 4, then push 5 → `full`=1, `count`=4, `overflow`=1; next pop returns 4.
- From empty, `rn` only → `underflow`=1, `dout_valid`=0, `dataout` holds its last value, `count`=0.
- Stack [10, 20] (20 on top), `wn`=`rn`=1 with `datain`=30 → `dataout`=20, `dout_valid`=1, `count`=2; following pops return 30 then 10. On empty, `wn`=`rn`=1 with `datain`=77 → `dataout`=77, `count`=0.
- After 3 pushes, assert `reset` for one cycle with `wn`=1 → `count`=0, `empty`=1, flags cleared; a subsequent pop sets `underflow`=1.
